// File: rtl/interleaver_frame_ctrl.sv
// Frame sequencer for the bit interleaver core: takes one frame from upstream, runs the core
// under a watchdog, then hands the permuted frame downstream. One frame in flight at a time.
module interleaver_frame_ctrl #(
    parameter int N       = 1024,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    output logic [N-1:0]     core_data,
    output logic             core_start,
    output logic             core_abort,
    input  logic             core_done,
    input  logic [N-1:0]     core_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             busy,
    output logic             timeout_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [N-1:0]      core_data_q, core_data_d;
    logic [N-1:0]      out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              in_ready_q, in_ready_d;
    logic              timeout_err_q, timeout_err_d;
    logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            core_data_q   <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            in_ready_q    <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            core_data_q   <= core_data_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            in_ready_q    <= in_ready_d;
            timeout_err_q <= timeout_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    // Pulses are decoded from state so an async reset can never leave one dangling.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        core_data_d   = core_data_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        frame_cnt_d   = frame_cnt_q;
        timeout_err_d = timeout_err_q;
        core_start    = 1'b0;
        core_abort    = 1'b0;

        if (err_clr) begin
            timeout_err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    core_data_d = in_data;
                    state_d     = START;
                end
            end
            START: begin
                core_start = 1'b1;
                timer_d    = '0;
                state_d    = RUN;
            end
            RUN: begin
                timer_d = timer_q + TW'(1);
                // A completion in the expiry cycle still counts as success.
                if (core_done) begin
                    out_data_d  = core_result;
                    out_valid_d = 1'b1;
                    state_d     = DRAIN;
                end else if (timer_q == TIMER_LAST) begin
                    core_abort    = 1'b1;
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            DRAIN: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    frame_cnt_d = frame_cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == IDLE);
    end

    assign in_ready    = in_ready_q;
    assign core_data   = core_data_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign busy        = (state_q != IDLE);
    assign timeout_err = timeout_err_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_interleaver_frame_ctrl.sv
// Directed bench for interleaver_frame_ctrl with N=8, TIMEOUT=16, CNT_W=4.
`timescale 1ns/1ps
module tb_interleaver_frame_ctrl;

    localparam int N       = 8;
    localparam int TIMEOUT = 16;
    localparam int CNT_W   = 4;

    logic             clock;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic [N-1:0]     core_data;
    logic             core_start;
    logic             core_abort;
    logic             core_done;
    logic [N-1:0]     core_result;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     out_data;
    logic             busy;
    logic             timeout_err;
    logic             err_clr;
    logic [CNT_W-1:0] frame_cnt;

    int passCount  = 0;
    int totalCount = 0;
    logic [CNT_W-1:0] expCnt;
    logic [N-1:0]     expOut;

    interleaver_frame_ctrl #(.N(N), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .core_data   (core_data),
        .core_start  (core_start),
        .core_abort  (core_abort),
        .core_done   (core_done),
        .core_result (core_result),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_clr     (err_clr),
        .frame_cnt   (frame_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic v, input logic [N-1:0] d, input logic done,
                                 input logic [N-1:0] res, input logic ordy, input logic clr);
        in_valid    = v;
        in_data     = d;
        core_done   = done;
        core_result = res;
        out_ready   = ord_y_fix(ordy);
        err_clr     = clr;
    endtask

    function automatic logic ord_y_fix(input logic x);
        return x;
    endfunction

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);

        // Reset values, before and across clock edges
        #2;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_core_data", core_data, 0);
        tick();
        tick();
        checkOutput("rst_hold_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_core_start", core_start, 0);
        checkOutput("rst_core_abort", core_abort, 0);
        checkOutput("rst_timeout_err", timeout_err, 0);
        checkOutput("rst_frame_cnt", frame_cnt, 0);
        rst_n = 1'b1;
        settle();
        checkOutput("rel_in_ready_pre_edge", in_ready, 0);
        tick();
        checkOutput("rel_in_ready", in_ready, 1);
        checkOutput("rel_busy", busy, 0);

        // Frame A5 -> 5A, core_done 5 cycles after core_start
        applyStimulus(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("f1_core_start", core_start, 1);
        checkOutput("f1_core_data", core_data, 8'hA5);
        checkOutput("f1_in_ready", in_ready, 0);
        checkOutput("f1_busy", busy, 1);
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("f1_start_one_cycle", core_start, 0);
        for (int i = 0; i < 4; i++) tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0);
        settle();
        checkOutput("f1_out_valid_at_done", out_valid, 0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("f1_out_valid", out_valid, 1);
        checkOutput("f1_out_data", out_data, 8'h5A);
        checkOutput("f1_cnt_before", frame_cnt, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("f1_frame_cnt", frame_cnt, 1);
        checkOutput("f1_out_valid_drop", out_valid, 0);
        checkOutput("f1_in_ready_back", in_ready, 1);

        // Backpressure: 3C -> C3, new frame FF waits upstream
        applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'hC3, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("bp_out_valid", out_valid, 1);
            checkOutput("bp_out_data", out_data, 8'hC3);
            checkOutput("bp_in_ready", in_ready, 0);
            checkOutput("bp_core_data", core_data, 8'h3C);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("bp_frame_cnt", frame_cnt, 2);
        checkOutput("bp_in_ready", in_ready, 1);
        checkOutput("bp_core_data_kept", core_data, 8'h3C);
        tick();
        checkOutput("bp_held_frame_accepted", core_data, 8'hFF);
        checkOutput("bp_held_core_start", core_start, 1);
        in_valid = 1'b0;

        // Watchdog on frame FF: abort on 16th RUN cycle
        tick();
        for (int i = 0; i < 14; i++) begin
            tick();
            checkOutput("wd_no_early_abort", core_abort, 0);
        end
        tick();
        checkOutput("wd_abort", core_abort, 1);
        checkOutput("wd_err_not_yet", timeout_err, 0);
        tick();
        checkOutput("wd_abort_one_cycle", core_abort, 0);
        checkOutput("wd_timeout_err", timeout_err, 1);
        checkOutput("wd_frame_cnt", frame_cnt, 2);
        checkOutput("wd_in_ready", in_ready, 1);
        checkOutput("wd_busy", busy, 0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checkOutput("wd_err_clr", timeout_err, 0);

        // core_done on the 16th RUN cycle wins over expiry
        applyStimulus(1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 15; i++) tick();
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0);
        settle();
        checkOutput("bd_done_no_abort", core_abort, 0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("bd_out_valid", out_valid, 1);
        checkOutput("bd_out_data", out_data, 8'h22);
        checkOutput("bd_no_err", timeout_err, 0);
        tick();
        out_ready = 1'b0;
        checkOutput("bd_frame_cnt", frame_cnt, 3);

        // Expiry with err_clr in the same cycle: set wins
        applyStimulus(1'b1, 8'h44, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 15; i++) tick();
        err_clr = 1'b1;
        settle();
        checkOutput("sc_abort", core_abort, 1);
        tick();
        checkOutput("sc_set_wins", timeout_err, 1);
        tick();
        err_clr = 1'b0;
        checkOutput("sc_cleared", timeout_err, 0);

        // Spurious core_done in IDLE and START is ignored
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0);
        tick();
        checkOutput("sp_idle_busy", busy, 0);
        checkOutput("sp_idle_out_valid", out_valid, 0);
        checkOutput("sp_idle_out_data", out_data, 8'h22);
        checkOutput("sp_idle_cnt", frame_cnt, 3);
        applyStimulus(1'b1, 8'h66, 1'b1, 8'h77, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        checkOutput("sp_start_out_valid", out_valid, 0);
        tick();
        core_done = 1'b0;
        checkOutput("sp_run_out_valid", out_valid, 0);
        checkOutput("sp_run_busy", busy, 1);
        checkOutput("sp_run_out_data", out_data, 8'h22);
        applyStimulus(1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("sp_out_data", out_data, 8'h99);
        tick();
        out_ready = 1'b0;
        checkOutput("sp_frame_cnt", frame_cnt, 4);

        // Twelve more frames take the counter from 4 through 15 to 0
        expCnt = 4'd4;
        for (int k = 0; k < 12; k++) begin
            expOut = 8'(k * 29 + 3);
            applyStimulus(1'b1, 8'(k), 1'b0, 8'h00, 1'b0, 1'b0);
            tick();
            applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
            tick();
            applyStimulus(1'b0, 8'h00, 1'b1, expOut, 1'b0, 1'b0);
            tick();
            applyStimulus(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
            checkOutput("wr_out_data", out_data, expOut);
            tick();
            out_ready = 1'b0;
            expCnt = expCnt + 4'd1;
            checkOutput("wr_frame_cnt", frame_cnt, expCnt);
        end
        checkOutput("wr_wrapped_zero", frame_cnt, 0);

        // Async reset in the middle of RUN
        applyStimulus(1'b1, 8'hAB, 1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        checkOutput("ar_pre_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("ar_busy", busy, 0);
        checkOutput("ar_core_abort", core_abort, 0);
        checkOutput("ar_core_data", core_data, 0);
        checkOutput("ar_in_ready", in_ready, 0);
        checkOutput("ar_frame_cnt", frame_cnt, 0);
        tick();
        checkOutput("ar_hold_abort", core_abort, 0);
        checkOutput("ar_hold_out_valid", out_valid, 0);
        rst_n = 1'b1;
        tick();
        checkOutput("ar_in_ready_back", in_ready, 1);
        checkOutput("ar_cnt_after", frame_cnt, 0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
